serial_sum_collector: RTL and testbench
=======================================

# serial_sum_collector

Downstream stage of the 8-bit serial adder datapath. Deserializes the LSB-first sum bit stream produced by the Mealy-machine adder, captures the final carry, and presents each completed word as a parallel result on a valid/ready handshake. Tracks framing and overrun errors so the consumer can detect lost or malformed words.

## Interface
- WIDTH, 8: result word width and number of serial bits per word.
- CNT_W, 4: bit-counter width; must satisfy 2^CNT_W > WIDTH.
- i_clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_valid  input  1  s_in and c_in are valid this cycle.
- start  input  1  qualified by bit_valid; marks the first (LSB) bit of a word.
- s_in  input  1  serial sum bit, LSB first.
- c_in  input  1  adder carry state; sampled only with the last (MSB) bit and taken as carry-out.
- res_ready  input  1  consumer accepts the result this cycle.
- err_clr  input  1  clears both sticky error flags.
- res_valid  output  1  res_sum and res_cout hold a completed word.
- res_sum  output  WIDTH  assembled sum, bit k is the k-th serial bit received.
- res_cout  output  1  carry-out of the MSB addition.
- busy  output  1  high while in COLLECT.
- bit_cnt  output  CNT_W  number of bits captured for the current word.
- frame_err  output  1  sticky; a word was aborted by a new start.
- overrun  output  1  sticky; a completed word was dropped.

## Operation
- FSM states: IDLE and COLLECT. res_valid is a separate output-register flag, independent of FSM state.
- Shift register: each accepted bit shifts right and enters at bit WIDTH-1. After WIDTH bits, the first bit received sits at bit 0.
- IDLE:
  - bit_valid & start → load the first bit, bit_cnt=1, go to COLLECT.
  - bit_valid & !start → ignore the bit; no error.
  - WIDTH=1 edge case is not supported.
- COLLECT:
  - bit_valid low → hold all state (stall); no timeout.
  - bit_valid & !start → shift the bit in, bit_cnt+1.
  - bit_valid & start → set frame_err, discard the partial word, load this bit as a new first bit, bit_cnt=1, stay in COLLECT.
- Completion: the cycle in which the WIDTH-th bit is accepted.
  - Form word = {s_in, shift[WIDTH-1:1]} and cout = c_in.
  - bit_cnt returns to 0 and the FSM returns to IDLE.
- Output register, evaluated at completion:
  - !res_valid, or res_valid & res_ready → load word and cout; res_valid=1.
  - res_valid & !res_ready → drop the new word, keep the old result, set overrun.
- Without completion, res_valid & res_ready → res_valid=0 next cycle. res_sum and res_cout keep their last values, which are don't-care while invalid.
- res_sum and res_cout are stable while res_valid & !res_ready.
- err_clr clears both flags. If a new error occurs in the same cycle as err_clr, the error wins and the flag stays set.
- Reset values: FSM=IDLE, shift=0, bit_cnt=0, busy=0, res_valid=0, res_sum=0, res_cout=0, frame_err=0, overrun=0.
- Reset mid-word or with a pending result discards everything; no flags are set.

## Timing
- Bit acceptance takes effect at the clock edge where bit_valid=1.
- Latency: res_valid rises the cycle after the WIDTH-th bit is accepted. With no stalls, that is WIDTH cycles after the start bit.
- Back-to-back words are supported: a start may arrive in the cycle immediately after completion, at full rate of one bit per cycle.
- Consumer handshake: a transfer happens on res_valid & res_ready at a clock edge. res_ready is allowed to be asserted while res_valid is low; it has no effect.
- busy equals (state==COLLECT) and is registered.
- Error flags rise the cycle after the offending event.

## Test plan
- Basic word: stream 0x35+0x4A (sum bits of 0x7F LSB first, c_in=0 on the last bit), res_ready=1 → after 8 bits, res_valid=1 for one cycle with res_sum=0x7F, res_cout=0, no flags set.
- Carry out: sum bits of 0xFF+0x01 (0x00, c_in=1 on the last bit) → res_sum=0x00, res_cout=1.
- Stalls: word 0xA5 with bit_valid deasserted for 3 cycles after bit 2 and 1 cycle after bit 6 → res_sum=0xA5; busy stays high through the stalls; bit_cnt holds during each stall.
- Backpressure and overrun:
  - res_ready=0; stream 0x11 then 0x22 back-to-back → res_sum stays 0x11, overrun=1.
  - Raise res_ready one cycle, then err_clr → res_valid=0, overrun=0.
  - Same case with res_ready=1 exactly on the completion cycle of 0x22 → res_sum=0x22, overrun=0.
- Restart: start asserted at bit 5 of a word, then 8 bits of 0x3C → frame_err=1, res_sum=0x3C; the aborted word never appears on the output.
- Reset mid-word: assert reset after 4 bits, then a full word 0x96 → all outputs at reset values for the reset cycle, then res_sum=0x96, no flags set.

Source files
------------

// File: rtl/serial_sum_collector_if.sv
// Bit-stream and result handshake bundle for serial_sum_collector.
// slave is the collector side and master is the producer/consumer side.
interface serial_sum_collector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             bit_valid;
  logic             start;
  logic             s_in;
  logic             c_in;
  logic             res_ready;
  logic             err_clr;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_err;
  logic             overrun;

  modport slave (
    input  bit_valid, start, s_in, c_in, res_ready, err_clr,
    output res_valid, res_sum, res_cout, busy, bit_cnt, frame_err, overrun
  );

  modport master (
    output bit_valid, start, s_in, c_in, res_ready, err_clr,
    input  res_valid, res_sum, res_cout, busy, bit_cnt, frame_err, overrun
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Deserializes an LSB-first sum stream into a word; res_valid rises the cycle after the last bit.
// Backpressure: a word completing while the result is held unaccepted is dropped and flags overrun.
module serial_sum_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  i_clk,
  input  logic                  reset,
  serial_sum_collector_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             complete;
  logic             ferr_set;
  logic             ovr_set;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] shifted;

  assign first_word = {bus.s_in, {(WIDTH-1){1'b0}}};
  assign shifted    = {bus.s_in, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bit_valid && bus.start) begin
          shift_d = first_word;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.bit_valid) begin
          if (bus.start) begin
            // A fresh start mid-word abandons the partial word.
            ferr_set = 1'b1;
            shift_d  = first_word;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            complete = 1'b1;
            shift_d  = shifted;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d   = vld_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovr_set = 1'b0;
    if (complete) begin
      if (!vld_q || bus.res_ready) begin
        vld_d  = 1'b1;
        sum_d  = shifted;
        cout_d = bus.c_in;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (vld_q && bus.res_ready) begin
      vld_d = 1'b0;
    end
    // A new error in the clearing cycle keeps its flag set.
    ferr_d = ferr_set | (ferr_q & ~bus.err_clr);
    ovr_d  = ovr_set  | (ovr_q  & ~bus.err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.res_valid = vld_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.busy      = (state_q == COLLECT);
  assign bus.bit_cnt   = cnt_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector: words, stalls, backpressure, restart and reset.
module tb_serial_sum_collector;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  serial_sum_collector_if #(.WIDTH(8), .CNT_W(4)) bus ();

  serial_sum_collector #(.WIDTH(8), .CNT_W(4)) dut (
    .i_clk (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic c, input logic st);
    bus.bit_valid = 1'b1;
    bus.s_in      = s;
    bus.c_in      = c;
    bus.start     = st;
    tick();
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  // c_in is driven inverted on all but the last bit, so only the MSB carry may be taken.
  task automatic send_word(input logic [7:0] w, input logic c);
    for (int i = 0; i < 8; i++)
      send_bit(w[i], (i == 7) ? c : ~c, i == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b sum=%h cout=%b busy=%b cnt=%0d ferr=%b ovr=%b, want all zero",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.res_ready = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.bit_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL idle_ignore: got busy=%b cnt=%0d, want busy=0 cnt=0", bus.busy, bus.bit_cnt);
    end
    send_bit(1'b1, 1'b1, 1'b1);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.bit_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL first_bit: got busy=%b cnt=%0d, want busy=1 cnt=1", bus.busy, bus.bit_cnt);
    end
    for (int i = 1; i < 8; i++)
      send_bit(i < 7 ? 1'b1 : 1'b0, i == 7 ? 1'b0 : 1'b1, 1'b0);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h7F || bus.res_cout !== 1'b0 ||
        bus.busy !== 1'b0 || bus.bit_cnt !== 4'd0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_word: got valid=%b sum=%h cout=%b busy=%b cnt=%0d ferr=%b ovr=%b, want 1 7f 0 0 0 0 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun);
    end
    tick();
    tests_run++;
    if (bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_consume: got valid=%b, want 0", bus.res_valid);
    end
  endtask

  task automatic test_carry();
    bus.res_ready = 1'b1;
    send_word(8'h00, 1'b1);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h00 || bus.res_cout !== 1'b1) begin
      tests_failed++;
      $display("FAIL carry_out: got valid=%b sum=%h cout=%b, want 1 00 1", bus.res_valid, bus.res_sum, bus.res_cout);
    end
    tick();
  endtask

  task automatic test_stalls();
    logic [7:0] w;
    bus.res_ready = 1'b1;
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i], 1'b0, i == 0);
      if (i == 1 || i == 5) begin
        for (int k = 0; k < (i == 1 ? 3 : 1); k++) begin
          tick();
          tests_run++;
          if (bus.busy !== 1'b1 || bus.bit_cnt !== 4'(i + 1) || bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold: got busy=%b cnt=%0d valid=%b, want busy=1 cnt=%0d valid=0",
                     bus.busy, bus.bit_cnt, bus.res_valid, i + 1);
          end
        end
      end
    end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'hA5 || bus.res_cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_word: got valid=%b sum=%h cout=%b, want 1 a5 0", bus.res_valid, bus.res_sum, bus.res_cout);
    end
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    bus.res_ready = 1'b0;
    send_word(8'h11, 1'b0);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h11) begin
      tests_failed++;
      $display("FAIL hold_first: got valid=%b sum=%h, want 1 11", bus.res_valid, bus.res_sum);
    end
    send_word(8'h22, 1'b0);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h11 || bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_drop: got valid=%b sum=%h ovr=%b, want 1 11 1", bus.res_valid, bus.res_sum, bus.overrun);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky: got valid=%b ovr=%b, want 0 1", bus.res_valid, bus.overrun);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got valid=%b ovr=%b, want 0 0", bus.res_valid, bus.overrun);
    end
    // Consumer accepts exactly on the completion edge of the second word.
    send_word(8'h11, 1'b0);
    w = 8'h22;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bus.res_ready = 1'b1;
      send_bit(w[i], 1'b0, i == 0);
    end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h22 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_on_complete: got valid=%b sum=%h ovr=%b, want 1 22 0", bus.res_valid, bus.res_sum, bus.overrun);
    end
    tick();
  endtask

  task automatic test_restart();
    logic [7:0] w;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 1'b1, i == 0);
    w = 8'h3C;
    bus.err_clr = 1'b1;
    send_bit(w[0], 1'b0, 1'b1);
    bus.err_clr = 1'b0;
    tests_run++;
    if (bus.frame_err !== 1'b1 || bus.bit_cnt !== 4'd1 || bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_flag: got ferr=%b cnt=%0d busy=%b valid=%b, want 1 1 1 0",
               bus.frame_err, bus.bit_cnt, bus.busy, bus.res_valid);
    end
    for (int i = 1; i < 8; i++) begin
      send_bit(w[i], 1'b0, 1'b0);
      if (i < 7 && bus.res_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL restart_no_partial: got valid=%b at bit %0d, want 0", bus.res_valid, i);
      end
    end
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h3C || bus.frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_word: got valid=%b sum=%h ferr=%b, want 1 3c 1", bus.res_valid, bus.res_sum, bus.frame_err);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    tests_run++;
    if (bus.frame_err !== 1'b0 || bus.res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_clear: got ferr=%b valid=%b, want 0 0", bus.frame_err, bus.res_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    send_word(8'h55, 1'b1);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 1'b0, i == 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid=%b sum=%h cout=%b busy=%b cnt=%0d ferr=%b ovr=%b, want all zero",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun);
    end
    bus.res_ready = 1'b1;
    send_word(8'h96, 1'b0);
    tests_run++;
    if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h96 || bus.res_cout !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset_word: got valid=%b sum=%h cout=%b ferr=%b ovr=%b, want 1 96 0 0 0",
               bus.res_valid, bus.res_sum, bus.res_cout, bus.frame_err, bus.overrun);
    end
    tick();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
    bus.s_in      = 1'b0;
    bus.c_in      = 1'b0;
    bus.res_ready = 1'b0;
    bus.err_clr   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_stalls();
    test_overrun();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
